inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 24 ++
 rtl/inst_enc_fifo.sv | 37 +++
 rtl/inst_encoder.sv | 62 ++++++
 tb/tb_inst_encoder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: instruction formats, opcodes and immediate range helper shared by the encoder.
package inst_encoder_pkg;
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_J = 3'd4,
    FMT_U = 3'd5
  } fmt_e;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [31:0] NOP = {12'd0, 5'd0, 3'd0, 5'd0, OP_IMM};
  // True when v[63:lsb] are all copies of one bit, i.e. v fits a signed field of lsb+1 bits.
  function automatic logic sext_fits(input logic [63:0] v, input int unsigned lsb);
    logic [63:0] s;
    s = $signed(v) >>> lsb;
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/inst_enc_fifo.sv
// inst_enc_fifo: power-of-two circular buffer holding encoded instructions in order.
module inst_enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded fields into a 32-bit instruction, range-checks the immediate, buffers results.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] err_count
);
  fmt_e fmt;
  logic [31:0] enc;
  logic ok, push, pop, full, empty;
  logic [32:0] head;
  assign fmt = fmt_e'(in_fmt);
  assign enc =
    fmt == FMT_R ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode} :
    fmt == FMT_I ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
    fmt == FMT_S ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
    fmt == FMT_B ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode} :
    fmt == FMT_J ? {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode} :
    fmt == FMT_U ? {in_imm[31:12], in_rd, in_opcode} : NOP;
  assign ok =
    fmt == FMT_R ? 1'b1 :
    fmt == FMT_I || fmt == FMT_S ? sext_fits(in_imm, 11) :
    fmt == FMT_B ? sext_fits(in_imm, 12) && !in_imm[0] :
    fmt == FMT_J ? sext_fits(in_imm, 20) && !in_imm[0] :
    fmt == FMT_U ? in_imm[11:0] == '0 && sext_fits(in_imm, 31) : 1'b0;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign {out_err, out_inst} = head;
  inst_enc_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({!ok, ok ? enc : NOP}),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) err_count <= '0;
    else if (push && !ok && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench for inst_encoder covering spec vectors, backpressure, reset and random traffic.
module tb_inst_encoder;
  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
  } req_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0] in_fmt, in_funct3;
  logic [6:0] in_opcode, in_funct7;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [63:0] in_imm;
  logic [31:0] out_inst;
  logic [15:0] err_count;
  int checks = 0;
  int errors = 0;
  int exp_errs = 0;
  logic [32:0] q[$];

  inst_encoder #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic req_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [63:0] imm);
    req_t r;
    r.fmt = f; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  function automatic logic [32:0] model(input req_t r);
    logic [31:0] i;
    logic ok;
    longint s;
    s = r.imm;
    i = '0;
    ok = 1'b1;
    i[6:0] = r.op;
    case (r.fmt)
      3'd0: begin i[31:25] = r.f7; i[24:20] = r.rs2; i[19:15] = r.rs1; i[14:12] = r.f3; i[11:7] = r.rd; end
      3'd1: begin
        i[31:20] = r.imm[11:0]; i[19:15] = r.rs1; i[14:12] = r.f3; i[11:7] = r.rd;
        ok = s >= -64'sd2048 && s <= 64'sd2047;
      end
      3'd2: begin
        i[31:25] = r.imm[11:5]; i[24:20] = r.rs2; i[19:15] = r.rs1; i[14:12] = r.f3; i[11:7] = r.imm[4:0];
        ok = s >= -64'sd2048 && s <= 64'sd2047;
      end
      3'd3: begin
        i[31] = r.imm[12]; i[30:25] = r.imm[10:5]; i[24:20] = r.rs2; i[19:15] = r.rs1; i[14:12] = r.f3;
        i[11:8] = r.imm[4:1]; i[7] = r.imm[11];
        ok = s >= -64'sd4096 && s <= 64'sd4095 && !r.imm[0];
      end
      3'd4: begin
        i[31] = r.imm[20]; i[30:21] = r.imm[10:1]; i[20] = r.imm[11]; i[19:12] = r.imm[19:12]; i[11:7] = r.rd;
        ok = s >= -64'sd1048576 && s <= 64'sd1048575 && !r.imm[0];
      end
      3'd5: begin
        i[31:12] = r.imm[31:12]; i[11:7] = r.rd;
        ok = r.imm[11:0] == 12'd0 && s >= -64'sd2147483648 && s <= 64'sd2147483647;
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, i} : {1'b1, 32'h00000013};
  endfunction

  task automatic send(input req_t r, input logic [32:0] e);
    int n;
    n = 0;
    in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept in_ready=%b required 1 after %0d cycles", in_ready, n);
    end else begin
      q.push_back(e);
      if (e[32] && exp_errs != 65535) exp_errs++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 64'd3000;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q.delete(); exp_errs = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got %h want 00000000", out_inst); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_push got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_vectors;
    req_t va[8];
    logic [32:0] ea[8];
    int cnt_after[2];
    cnt_after[0] = 1; cnt_after[1] = 4;
    va[0] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF); ea[0] = {1'b0, 32'hFFF00093};
    va[1] = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 64'd8);               ea[1] = {1'b0, 32'h0020A423};
    va[2] = mk(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);          ea[2] = {1'b0, 32'h123452B7};
    va[3] = mk(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345001);          ea[3] = {1'b1, 32'h00000013};
    va[4] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3);                 ea[4] = {1'b1, 32'h00000013};
    va[5] = mk(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h100000);            ea[5] = {1'b1, 32'h00000013};
    va[6] = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);                 ea[6] = {1'b0, 32'h002081B3};
    va[7] = mk(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);                 ea[7] = {1'b1, 32'h00000013};
    for (int p = 0; p < 2; p++) begin
      fork
        begin
          for (int i = 0; i < 4; i++) begin
            send(va[p*4+i], ea[p*4+i]);
            if (p == 0 && i == 0) begin
              checks++;
              if (out_valid !== 1'b1 || out_inst !== 32'hFFF00093 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL vec_latency got valid=%b inst=%h err=%b want 1 fff00093 0", out_valid, out_inst, out_err);
              end
            end
          end
        end
        begin
          int got, t;
          logic [32:0] e;
          got = 0; t = 0;
          while (got < 4 && t < 1000) begin
            @(negedge clk); t++;
            out_ready = $urandom_range(0, 3) != 0;
            if (out_valid && out_ready) begin
              checks++;
              if (q.size() == 0) begin errors++; $display("FAIL vec_unexpected got %b_%h want nothing", out_err, out_inst); end
              else begin
                e = q.pop_front();
                if ({out_err, out_inst} !== e) begin errors++; $display("FAIL vec_out got %b_%h want %b_%h", out_err, out_inst, e[32], e[31:0]); end
              end
              got++;
            end
          end
          if (got < 4) begin checks++; errors++; $display("FAIL vec_timeout got %0d outputs want 4", got); end
          @(posedge clk); #1; out_ready = 1'b0;
        end
      join
      checks++;
      if (err_count !== 16'(cnt_after[p])) begin errors++; $display("FAIL vec_err_count got %0d want %0d", err_count, cnt_after[p]); end
    end
  endtask

  task automatic test_back_to_back;
    req_t a, b, c;
    a = mk(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5);
    b = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
    c = mk(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);
    out_ready = 1'b0;
    send(a, {1'b0, 32'h00500113});
    send(b, {1'b0, 32'h002081B3});
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got in_ready=%b want 0", in_ready); end
    in_fmt = c.fmt; in_opcode = c.op; in_rd = c.rd; in_imm = c.imm; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h00500113 || out_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold got ready=%b valid=%b inst=%h err=%b want 0 1 00500113 0", in_ready, out_valid, out_inst, out_err);
      end
    end
    fork
      send(c, {1'b0, 32'h123452B7});
      begin
        int got, t;
        logic [32:0] e;
        got = 0; t = 0;
        while (got < 3 && t < 100) begin
          @(negedge clk); t++;
          out_ready = 1'b1;
          if (out_valid) begin
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL b2b_unexpected got %b_%h want nothing", out_err, out_inst); end
            else begin
              e = q.pop_front();
              if ({out_err, out_inst} !== e) begin errors++; $display("FAIL b2b_order got %b_%h want %b_%h", out_err, out_inst, e[32], e[31:0]); end
            end
            got++;
          end
        end
        if (got < 3) begin checks++; errors++; $display("FAIL b2b_timeout got %0d outputs want 3", got); end
        @(posedge clk); #1; out_ready = 1'b0;
      end
    join
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1), {1'b0, 32'h00100093});
    send(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3), {1'b1, 32'h00000013});
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_count !== 16'(exp_errs)) begin
      errors++;
      $display("FAIL mid_prefill got valid=%b ready=%b errs=%0d want 1 0 %0d", out_valid, in_ready, err_count, exp_errs);
    end
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q.delete(); exp_errs = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL mid_err_count got %0d want 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got out_valid=%b inst=%h want 0", out_valid, out_inst); end
    end
    out_ready = 1'b0;
    send(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 64'd8), {1'b0, 32'h0020A423});
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0020A423 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_fresh got valid=%b inst=%h err=%b want 1 0020a423 0", out_valid, out_inst, out_err);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    void'(q.pop_front());
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_drain got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_random;
    localparam int N = 200;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          req_t r;
          logic [31:0] x;
          logic [63:0] imm;
          x = $urandom;
          case ($urandom_range(0, 3))
            0: imm = {{51{x[12]}}, x[12:0]};
            1: imm = {{43{x[20]}}, x[20:0]};
            2: imm = {{32{x[31]}}, x} & ($urandom_range(0, 1) != 0 ? ~64'hFFF : ~64'h0);
            default: imm = {$urandom, $urandom};
          endcase
          r = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), imm);
          send(r, model(r));
        end
      end
      begin
        int got, t;
        logic [32:0] e;
        got = 0; t = 0;
        while (got < N && t < 5000) begin
          @(negedge clk); t++;
          out_ready = $urandom_range(0, 2) != 0;
          if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL rand_unexpected got %b_%h want nothing", out_err, out_inst); end
            else begin
              e = q.pop_front();
              if ({out_err, out_inst} !== e) begin errors++; $display("FAIL rand_out got %b_%h want %b_%h", out_err, out_inst, e[32], e[31:0]); end
            end
            got++;
          end
        end
        if (got < N) begin checks++; errors++; $display("FAIL rand_timeout got %0d outputs want %0d", got, N); end
        @(posedge clk); #1; out_ready = 1'b0;
      end
    join
    checks++; if (err_count !== 16'(exp_errs)) begin errors++; $display("FAIL rand_err_count got %0d want %0d", err_count, exp_errs); end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 64'd0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
